// File: rtl/switch_pkg.sv
// switch_pkg: shared defaults and helpers for the buffered NxN crossbar switch
package switch_pkg;
  localparam int NPORTS_DEF = 2;
  localparam int DWIDTH_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W      = 16;
  function automatic bit is_onehot(logic [7:0] v);
    return (v != '0) && ((v & (v - 8'd1)) == '0);
  endfunction
endpackage

// File: rtl/switch_nxn_buffered_if.sv
// switch_nxn_buffered_if: ingress and egress handshake bundle of the crossbar switch
interface switch_nxn_buffered_if import switch_pkg::*; #(
  parameter int NPORTS = NPORTS_DEF,
  parameter int DWIDTH = DWIDTH_DEF
);
  logic [NPORTS-1:0]             in_valid;
  logic [NPORTS-1:0]             in_ready;
  logic [NPORTS-1:0][DWIDTH-1:0] in_data;
  logic [NPORTS-1:0][NPORTS-1:0] in_dest;
  logic [NPORTS-1:0]             out_valid;
  logic [NPORTS-1:0]             out_ready;
  logic [NPORTS-1:0][DWIDTH-1:0] out_data;
  modport slave (input in_valid, in_data, in_dest, out_ready, output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, in_dest, out_ready, input in_ready, out_valid, out_data);
endinterface

// File: rtl/switch_fifo.sv
// switch_fifo: synchronous FIFO with registered full/empty flags derived from occupancy
module switch_fifo import switch_pkg::*; #(
  parameter int W = DWIDTH_DEF + NPORTS_DEF,
  parameter int D = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(D);
  logic [W-1:0]  mem_q [D];
  logic [W-1:0]  mem_d [D];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d, empty_q, empty_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d = cnt_d == (AW+1)'(D);
    empty_d = cnt_d == '0;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  assign full  = full_q;
  assign empty = empty_q;
  assign head  = mem_q[rd_q];
endmodule

// File: rtl/switch_nxn_buffered.sv
// switch_nxn_buffered: NxN crossbar, per-input FIFOs, per-output round-robin arbiter and register
// SWITCH_STATS_EN adds per-input saturating drop_cnt for invalid-destination words.
module switch_nxn_buffered import switch_pkg::*; #(
  parameter int NPORTS = NPORTS_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic clk,
  input logic resetN,
  switch_nxn_buffered_if.slave bus
`ifdef SWITCH_STATS_EN
  , output logic [NPORTS-1:0][CNT_W-1:0] drop_cnt
`endif
);
  localparam int PW = $clog2(NPORTS);
  logic [NPORTS-1:0]             acc, push, pop, full, empty;
  logic [DWIDTH+NPORTS-1:0]      head [NPORTS];
  logic [NPORTS-1:0]             gnt  [NPORTS];
  assign bus.in_ready = {NPORTS{resetN}} & ~full;
  for (genvar i = 0; i < NPORTS; i++) begin : g_in
    assign acc[i]  = bus.in_valid[i] & bus.in_ready[i];
    assign push[i] = acc[i] & is_onehot(8'(bus.in_dest[i]));
    switch_fifo #(.W(DWIDTH + NPORTS), .D(DEPTH)) u_fifo (
      .clk(clk), .resetN(resetN), .push(push[i]), .pop(pop[i]),
      .din({bus.in_dest[i], bus.in_data[i]}),
      .full(full[i]), .empty(empty[i]), .head(head[i])
    );
  end
  always_comb begin
    pop = '0;
    for (int j = 0; j < NPORTS; j++) pop = pop | gnt[j];
  end
  for (genvar j = 0; j < NPORTS; j++) begin : g_out
    logic              vld_q, vld_d, can, gv;
    logic [DWIDTH-1:0] dat_q, dat_d;
    logic [PW-1:0]     ptr_q, ptr_d, gi, cand;
    always_comb begin
      can = !vld_q || bus.out_ready[j];
      gv = 1'b0;
      gi = ptr_q;
      cand = ptr_q;
      for (int k = 1; k <= NPORTS; k++) begin
        cand = PW'((int'(ptr_q) + k) % NPORTS);
        if (can && !gv && !empty[cand] && head[cand][DWIDTH+j]) begin
          gv = 1'b1;
          gi = cand;
        end
      end
      vld_d = can ? gv : vld_q;
      dat_d = gv ? head[gi][DWIDTH-1:0] : dat_q;
      ptr_d = gv ? gi : ptr_q;
    end
    always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        ptr_q <= PW'(NPORTS - 1);
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
        ptr_q <= ptr_d;
      end
    assign gnt[j] = gv ? NPORTS'(1) << gi : '0;
    assign bus.out_valid[j] = vld_q;
    assign bus.out_data[j]  = dat_q;
  end
`ifdef SWITCH_STATS_EN
  logic [NPORTS-1:0][CNT_W-1:0] drop_q, drop_d;
  always_comb begin
    drop_d = drop_q;
    for (int i = 0; i < NPORTS; i++)
      drop_d[i] = (acc[i] && !push[i] && drop_q[i] != '1) ? drop_q[i] + 1'b1 : drop_q[i];
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) drop_q <= '0;
    else drop_q <= drop_d;
  assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_switch_nxn_buffered.sv
// tb_switch_nxn_buffered: scoreboard bench for the buffered 2x2 crossbar configuration
module tb_switch_nxn_buffered;
  import switch_pkg::*;
  localparam int NP = 2;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;
  switch_nxn_buffered_if #(.NPORTS(NP), .DWIDTH(DW)) bus ();
`ifdef SWITCH_STATS_EN
  logic [NP-1:0][CNT_W-1:0] drop_cnt;
`endif
  switch_nxn_buffered #(.NPORTS(NP), .DWIDTH(DW), .DEPTH(4)) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
`ifdef SWITCH_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q [NP][$];
  logic          hold_v [NP];
  logic [DW-1:0] hold_d [NP];
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.in_valid = '0;
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    for (int j = 0; j < NP; j++) exp_q[j].delete();
  endtask
  task automatic send(int i, logic [DW-1:0] d, logic [NP-1:0] dst);
    bit ok;
    int n;
    n = 0;
    bus.in_valid[i] = 1'b1;
    bus.in_data[i] = d;
    bus.in_dest[i] = dst;
    do begin
      @(negedge clk);
      ok = bus.in_ready[i];
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) chk($sformatf("send%0d_timeout", i), 64'd0, 64'd1);
    bus.in_valid[i] = 1'b0;
  endtask
  task automatic drain(string name, int budget);
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
  endtask
  initial begin
    for (int j = 0; j < NP; j++) hold_v[j] = 1'b0;
    forever begin
      @(negedge clk);
      for (int j = 0; j < NP; j++) begin
        if (!resetN) hold_v[j] = 1'b0;
        else begin
          if (hold_v[j]) begin
            chk($sformatf("out%0d_hold_valid", j), 64'(bus.out_valid[j]), 64'd1);
            chk($sformatf("out%0d_hold_data", j), 64'(bus.out_data[j]), 64'(hold_d[j]));
          end
          if (bus.out_valid[j] && bus.out_ready[j]) begin
            if (exp_q[j].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL out%0d_unexpected: got %0h expected no word", j, bus.out_data[j]);
            end else chk($sformatf("out%0d_data", j), 64'(bus.out_data[j]), 64'(exp_q[j].pop_front()));
          end
          hold_v[j] = bus.out_valid[j] && !bus.out_ready[j];
          hold_d[j] = bus.out_data[j];
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.in_dest = '0;
    bus.out_ready = '0;
    tick();
    bus.in_valid = 2'b11;
    bus.in_dest = {2'b01, 2'b10};
    tick();
    tick();
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_data", 64'(bus.out_data), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = '0;
    resetN = 1'b1;
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'd3);
    tick();
    bus.out_ready = 2'b11;
    bus.in_valid[0] = 1'b1;
    bus.in_data[0] = 32'hA5A5_0001;
    bus.in_dest[0] = 2'b10;
    exp_q[1].push_back(32'hA5A5_0001);
    tick();
    bus.in_valid[0] = 1'b0;
    @(negedge clk);
    chk("lat_early_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(bus.out_valid), 64'd2);
    chk("lat_data", 64'(bus.out_data[1]), 64'hA5A5_0001);
    drain("lat_drain", 10);
    do_reset();
    bus.out_ready = 2'b11;
    foreach (exp_q[0][k]) exp_q[0].delete();
    exp_q[0] = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202, 32'h103, 32'h203};
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 2'b11;
      bus.in_data[0] = 32'h100 + k;
      bus.in_data[1] = 32'h200 + k;
      bus.in_dest = {2'b01, 2'b01};
      @(negedge clk);
      chk("cont_in_ready", 64'(bus.in_ready), 64'd3);
      tick();
    end
    bus.in_valid = '0;
    drain("cont_drain", 20);
    do_reset();
    bus.out_ready = 2'b01;
    for (int k = 0; k < 5; k++) exp_q[1].push_back(32'hB000_0000 + k);
    for (int k = 0; k < 5; k++) send(0, 32'hB000_0000 + k, 2'b10);
    @(negedge clk);
    chk("bp_in_ready0", 64'(bus.in_ready[0]), 64'd0);
    chk("bp_out_valid1", 64'(bus.out_valid[1]), 64'd1);
    chk("bp_out_data1", 64'(bus.out_data[1]), 64'hB000_0000);
    repeat (3) tick();
    bus.out_ready = 2'b11;
    drain("bp_drain", 20);
    do_reset();
    bus.out_ready = 2'b11;
    exp_q[0].push_back(32'd3);
    send(1, 32'd1, 2'b00);
    send(1, 32'd2, 2'b11);
    send(1, 32'd3, 2'b01);
    drain("inv_drain", 10);
    repeat (3) tick();
    chk("inv_idle_valid", 64'(bus.out_valid), 64'd0);
`ifdef SWITCH_STATS_EN
    chk("drop_cnt1", 64'(drop_cnt[1]), 64'd2);
    chk("drop_cnt0", 64'(drop_cnt[0]), 64'd0);
`endif
    do_reset();
    bus.out_ready = 2'b00;
    send(0, 32'hC000_0001, 2'b01);
    send(0, 32'hC000_0002, 2'b01);
    send(0, 32'hC000_0003, 2'b01);
    @(negedge clk);
    chk("mid_valid_before", 64'(bus.out_valid[0]), 64'd1);
    tick();
    resetN = 1'b0;
    #1;
    chk("mid_valid_reset", 64'(bus.out_valid), 64'd0);
    chk("mid_data_reset", 64'(bus.out_data), 64'd0);
    tick();
    resetN = 1'b1;
    bus.out_ready = 2'b11;
    repeat (10) tick();
    chk("mid_after_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_after_ready", 64'(bus.in_ready), 64'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
